sram_sp_arb_ctrl: RTL and testbench

Controller for a single-port, byte-group-masked SRAM macro (256 x 172 bits, 4 mask lanes of 43 bits, 1-cycle read latency). It arbitrates one read requester and one write requester onto the shared RW port. Writes win conflicts, with a starvation limit that guarantees read progress. It optionally zero-fills the array after reset. It sits between the cache-side pipeline logic and the generated SRAM wrapper.

---
 rtl/sram_sp_arb_ctrl_if.sv | 28 ++
 rtl/sram_sp_arb_ctrl.sv | 112 +++++++++++
 tb/tb_sram_sp_arb_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_sp_arb_ctrl_if.sv
// Requester-side bus of sram_sp_arb_ctrl: read/write request handshakes and read response.
// master = cache-side pipeline, slave = controller.
interface sram_sp_arb_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 172,
    parameter int MASK_W = 4
);
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [MASK_W-1:0] wr_mask;
    logic [DATA_W-1:0] wr_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_mask, wr_data,
        input  rd_ready, wr_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_mask, wr_data,
        output rd_ready, wr_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_sp_arb_ctrl.sv
// Single-port masked SRAM controller: write-priority arbitration with read starvation limit.
// Optional post-reset zero-fill sweep, enabled by defining SRAM_CTRL_INIT_EN.
module sram_sp_arb_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 172,
    parameter int MASK_W       = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    sram_sp_arb_ctrl_if.slave  bus,
    output logic               init_done,
    output logic               sram_en,
    output logic               sram_wmode,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [MASK_W-1:0]  sram_wmask,
    output logic [DATA_W-1:0]  sram_wdata,
    input  logic [DATA_W-1:0]  sram_rdata
);
    localparam int              SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    logic              run;
    logic              in_init;
    logic [ADDR_W-1:0] sweep_addr;

`ifdef SRAM_CTRL_INIT_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] init_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + ADDR_W'(1);
            if (&init_cnt)
                state <= ST_RUN;
        end
    end

    assign init_done  = (state == ST_RUN);
    // Gate with reset_n so nothing reaches the macro while reset is held.
    assign in_init    = reset_n && (state == ST_INIT);
    assign run        = reset_n && (state == ST_RUN);
    assign sweep_addr = init_cnt;
`else
    assign init_done  = 1'b1;
    assign in_init    = 1'b0;
    assign run        = reset_n;
    assign sweep_addr = '0;
`endif

    logic [SC_W-1:0] starve_cnt;
    logic            rd_force;
    logic            rd_gnt;
    logic            wr_gnt;
    logic            rsp_vld_q;

    // Write wins a conflict unless the read has already lost STARVE_LIMIT times in a row.
    assign rd_force = (starve_cnt == SC_MAX);
    assign rd_gnt   = run && bus.rd_valid && (!bus.wr_valid || rd_force);
    assign wr_gnt   = run && bus.wr_valid && !(bus.rd_valid && rd_force);

    assign bus.rd_ready = rd_gnt;
    assign bus.wr_ready = wr_gnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (rd_gnt)
            starve_cnt <= '0;
        else if (wr_gnt && bus.rd_valid && starve_cnt != SC_MAX)
            starve_cnt <= starve_cnt + SC_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            rsp_vld_q <= 1'b0;
        else
            rsp_vld_q <= rd_gnt;
    end

    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_data  = sram_rdata;

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (in_init) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = sweep_addr;
            sram_wmask = '1;
        end else if (wr_gnt) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = bus.wr_addr;
            sram_wmask = bus.wr_mask;
            sram_wdata = bus.wr_data;
        end else if (rd_gnt) begin
            sram_en    = 1'b1;
            sram_addr  = bus.rd_addr;
        end
    end
endmodule

// File: tb/tb_sram_sp_arb_ctrl.sv
// Bench for sram_sp_arb_ctrl: behavioural SRAM macro, table vectors, directed corner cases
// and a randomized run against a reference memory/arbitration model. Works with or without SRAM_CTRL_INIT_EN.
module tb_sram_sp_arb_ctrl;
    localparam int AW = 8;
    localparam int DW = 172;
    localparam int MW = 4;
    localparam int SL = 3;
    localparam int LW = DW / MW;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] MASK_EXP = {{LW{1'b0}}, {LW{1'b1}}, {LW{1'b0}}, {LW{1'b1}}};

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sram_sp_arb_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

    logic          init_done;
    logic          sram_en;
    logic          sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    sram_sp_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .STARVE_LIMIT(SL)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .init_done  (init_done),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    function automatic logic [DW-1:0] rnd_word();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // Behavioural SRAM macro: contents start as garbage, 1-cycle read latency, lane-masked writes.
    logic [DW-1:0] mem [DEPTH];
    logic          mem_seeded = 1'b0;
    logic [DW-1:0] nw;
    always @(posedge clock) begin
        if (!mem_seeded) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= rnd_word();
            mem_seeded <= 1'b1;
        end else if (sram_en) begin
            if (sram_wmode) begin
                nw = mem[sram_addr];
                for (int l = 0; l < MW; l++)
                    if (sram_wmask[l]) nw[l*LW +: LW] = sram_wdata[l*LW +: LW];
                mem[sram_addr] <= nw;
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_known [DEPTH];
    int            losses;
    bit            pend;
    bit            pend_known;
    logic [DW-1:0] pend_data;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: entered just after a negedge, returns at the next negedge.
    task automatic cycle(input bit rv, input logic [AW-1:0] ra, input bit wv, input logic [AW-1:0] wa,
                         input logic [MW-1:0] wm, input logic [DW-1:0] wd, output bit rg, output bit wg);
        bit erg, ewg;
        bus.rd_valid = rv; bus.rd_addr = ra;
        bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_mask = wm; bus.wr_data = wd;
        #1;
        erg = rv && (!wv || losses >= SL);
        ewg = wv && !erg;
        rg = bus.rd_ready;
        wg = bus.wr_ready;
        chk("rd_ready", rg, erg);
        chk("wr_ready", wg, ewg);
        chk("rsp_valid", bus.rsp_valid, pend);
        if (pend && pend_known) chk("rsp_data", bus.rsp_data, pend_data);
        chk("sram_en", sram_en, erg || ewg);
        if (erg || ewg) begin
            chk("sram_addr", sram_addr, erg ? ra : wa);
            chk("sram_wmode", sram_wmode, ewg);
        end
        @(posedge clock);
        pend = erg;
        if (erg) begin
            pend_data  = ref_mem[ra];
            pend_known = ref_known[ra];
            losses     = 0;
        end else if (ewg) begin
            for (int l = 0; l < MW; l++)
                if (wm[l]) ref_mem[wa][l*LW +: LW] = wd[l*LW +: LW];
            if (wm == {MW{1'b1}}) ref_known[wa] = 1'b1;
            if (rv) losses++;
        end
        @(negedge clock);
    endtask

    task automatic model_reset();
        losses = 0;
        pend   = 1'b0;
    endtask

`ifdef SRAM_CTRL_INIT_EN
    // Observe the zero-fill sweep; stop_at >= 0 returns with the sweep sitting on that address.
    task automatic sweep(input int stop_at);
        int bad;
        bad = 0;
        bus.rd_valid = 1'b1;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            if (!(sram_en === 1'b1 && sram_wmode === 1'b1 && sram_wmask === {MW{1'b1}} &&
                  sram_wdata === '0 && sram_addr === AW'(i) && init_done === 1'b0 &&
                  bus.rd_ready === 1'b0 && bus.wr_ready === 1'b0)) bad++;
            if (i == stop_at) break;
            @(posedge clock);
            @(negedge clock);
        end
        chk("sweep_bad_cycles", bad, 0);
        if (stop_at < 0) begin
            for (int a = 0; a < DEPTH; a++) begin
                ref_mem[a]   = '0;
                ref_known[a] = 1'b1;
            end
            bus.rd_valid = 1'b0;
            bus.wr_valid = 1'b0;
            #1;
            chk("init_done_after_256", init_done, 1'b1);
            chk("idle_after_init_en", sram_en, 1'b0);
        end
    endtask
`endif

    typedef struct {
        bit            rv;
        logic [AW-1:0] ra;
        bit            wv;
        logic [AW-1:0] wa;
        logic [MW-1:0] wm;
        bit            exp_rg;
        bit            exp_wg;
    } vec_t;

    vec_t          tbl [12];
    logic [DW-1:0] wdat [4];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rg, wg;
        int pulses;

        for (int a = 0; a < DEPTH; a++) begin
            ref_known[a] = 1'b0;
            ref_mem[a]   = '0;
        end
        pend_data  = '0;
        pend_known = 1'b0;
        model_reset();
        bus.rd_valid = 1'b1; bus.rd_addr = '0;
        bus.wr_valid = 1'b1; bus.wr_addr = '0; bus.wr_mask = '0; bus.wr_data = '0;
        reset_n = 1'b0;

        #2;
        chk("rst_rd_ready", bus.rd_ready, 1'b0);
        chk("rst_wr_ready", bus.wr_ready, 1'b0);
        chk("rst_sram_en", sram_en, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
`ifdef SRAM_CTRL_INIT_EN
        chk("rst_init_done", init_done, 1'b0);
`else
        chk("rst_init_done", init_done, 1'b1);
`endif
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

`ifdef SRAM_CTRL_INIT_EN
        // Interrupt the sweep at address 100, then let a full sweep run.
        sweep(100);
        reset_n = 1'b0;
        #1;
        chk("midsweep_rst_sram_en", sram_en, 1'b0);
        chk("midsweep_rst_init_done", init_done, 1'b0);
        chk("midsweep_rst_wr_ready", bus.wr_ready, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        sweep(-1);

        cycle(1'b1, 8'h37, 1'b0, '0, '0, '0, rg, wg);
        #1;
        chk("rd37_rsp_valid", bus.rsp_valid, 1'b1);
        chk("rd37_data", bus.rsp_data, '0);
`else
        cycle(1'b0, '0, 1'b1, 8'h10, 4'hF, '0, rg, wg);
        chk("first_cycle_wr_grant", wg, 1'b1);
        chk("init_done_run", init_done, 1'b1);
`endif

        // Lane-masked write then read back.
        cycle(1'b0, '0, 1'b1, 8'h10, 4'b0101, {DW{1'b1}}, rg, wg);
        cycle(1'b1, 8'h10, 1'b0, '0, '0, '0, rg, wg);
        chk("mask_rd_grant", rg, 1'b1);
        #1;
        chk("mask_rsp_valid", bus.rsp_valid, 1'b1);
        chk("mask_rsp_data", bus.rsp_data, MASK_EXP);
        cycle(1'b0, '0, 1'b0, '0, '0, '0, rg, wg);
        #1;
        chk("mask_rsp_single", bus.rsp_valid, 1'b0);

        // Vector table; the leading read-only entry clears any starvation history.
        tbl[0] = '{1'b1, 8'h01, 1'b0, 8'h00, 4'hF, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 8'h21, 4'hF, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 4'hF, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++)
            tbl[3+i] = '{1'b1, AW'(i), 1'b1, AW'(8'h28 + i), 4'hF, (i % 4) == 3, (i % 4) != 3};
        tbl[11] = '{1'b1, 8'h05, 1'b1, 8'h30, 4'h3, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rv, tbl[i].ra, tbl[i].wv, tbl[i].wa, tbl[i].wm, rnd_word(), rg, wg);
            chk($sformatf("tbl%0d_rd_grant", i), rg, tbl[i].exp_rg);
            chk($sformatf("tbl%0d_wr_grant", i), wg, tbl[i].exp_wg);
        end

        // Back-to-back reads of 0..3 with fresh data.
        for (int k = 0; k < 4; k++) begin
            wdat[k] = rnd_word();
            cycle(1'b0, '0, 1'b1, AW'(k), 4'hF, wdat[k], rg, wg);
        end
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, AW'(k), 1'b0, '0, '0, '0, rg, wg);
            #1;
            if (bus.rsp_valid === 1'b1) pulses++;
            chk($sformatf("stream_data%0d", k), bus.rsp_data, wdat[k]);
        end
        chk("stream_pulses", pulses, 4);
        cycle(1'b0, '0, 1'b0, '0, '0, '0, rg, wg);

        // Randomized traffic over a small address window.
        for (int n = 0; n < 2000; n++)
            cycle($urandom_range(0, 99) < 60, AW'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 60, AW'($urandom_range(0, 15)),
                  MW'($urandom()), rnd_word(), rg, wg);

        // Reset while a read response is pending drops it.
        cycle(1'b1, 8'h02, 1'b0, '0, '0, '0, rg, wg);
        #1;
        chk("pend_rsp_before_rst", bus.rsp_valid, 1'b1);
        bus.rd_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("midread_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("midread_rst_rd_ready", bus.rd_ready, 1'b0);
        chk("midread_rst_sram_en", sram_en, 1'b0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
`ifdef SRAM_CTRL_INIT_EN
        sweep(-1);
`endif
        cycle(1'b1, 8'h03, 1'b1, 8'h40, 4'hF, rnd_word(), rg, wg);
        chk("post_rst_conflict_wr", wg, 1'b1);
        cycle(1'b1, 8'h03, 1'b0, '0, '0, '0, rg, wg);
        cycle(1'b0, '0, 1'b0, '0, '0, '0, rg, wg);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
